// File: rtl/cache_pkg.sv
// Shared types and default geometry for the set-associative data cache.
// Widths below describe the default build; modules re-derive them from their parameters.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REFILL,
        ST_WRITE
    } state_t;

    localparam int ADDR_W_D   = 16;
    localparam int DATA_W_D   = 32;
    localparam int NLINES_D   = 64;
    localparam int WAYS_D     = 2;
    localparam int WPL_D      = 4;

    localparam int SETS     = NLINES_D / WAYS_D;
    localparam int OFFSET_W = $clog2(WPL_D);
    localparam int INDEX_W  = $clog2(SETS);
    localparam int TAG_W    = ADDR_W_D - OFFSET_W - INDEX_W;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the cache: valid bits, tags and line data for every set.
// Performs its own tag compare and accepts word, invalidate and tag writes.
module cache_way
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W_D,
    parameter int N_SETS     = SETS,
    parameter int IDX_W      = INDEX_W,
    parameter int OFF_W      = OFFSET_W,
    parameter int TG_W       = TAG_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush_all,
    input  logic [IDX_W-1:0]      rd_index,
    input  logic [OFF_W-1:0]      rd_offset,
    input  logic [TG_W-1:0]       rd_tag,
    output logic                  hit,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_index,
    input  logic [OFF_W-1:0]      wr_offset,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  inv_en,
    input  logic                  tag_en,
    input  logic [TG_W-1:0]       wr_tag
);

    localparam int DEPTH = N_SETS * (1 << OFF_W);

    logic [N_SETS-1:0]     valid_q;
    logic [TG_W-1:0]       tag_q  [N_SETS];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];

    assign valid = valid_q[rd_index];
    assign hit   = valid && (tag_q[rd_index] == rd_tag);
    assign rdata = data_q[{rd_index, rd_offset}];

    // Valid bits: cleared by reset or flush, dropped at refill start, set on tag write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (flush_all) begin
            valid_q <= '0;
        end else begin
            if (inv_en) valid_q[wr_index] <= 1'b0;
            if (tag_en) valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; valid bits qualify them.
    always_ff @(posedge clock) begin
        if (tag_en) tag_q[wr_index] <= wr_tag;
        if (wr_en)  data_q[{wr_index, wr_offset}] <= wr_data;
    end

endmodule

// File: rtl/cache_assoc.sv
// Set-associative write-through data cache with multi-word refill and round-robin replacement.
// Define CACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module cache_assoc
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH     = ADDR_W_D,
    parameter int DATA_WIDTH     = DATA_W_D,
    parameter int NUM_LINES      = NLINES_D,
    parameter int WAYS           = WAYS_D,
    parameter int WORDS_PER_LINE = WPL_D
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  flush,
    output logic                  stall,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] rdata_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int NS = NUM_LINES / WAYS;
    localparam int OW = $clog2(WORDS_PER_LINE);
    localparam int IW = $clog2(NS);
    localparam int TW = ADDR_WIDTH - OW - IW;
    localparam int LW = ADDR_WIDTH - OW;
    localparam int WW = clog2_min1(WAYS);

    state_t          state_q, state_d;
    logic [LW-1:0]   line_q;
    logic [OW-1:0]   cnt_q;
    logic [WW-1:0]   victim_q;
    logic            use_ptr_q;
    logic [WW-1:0]   ptr_q [NS];

    logic [OW-1:0]   req_off;
    logic [IW-1:0]   req_idx;
    logic [TW-1:0]   req_tag;
    logic [IW-1:0]   line_idx;
    logic [TW-1:0]   line_tag;

    logic [WAYS-1:0]       way_hit, way_valid;
    logic [WAYS-1:0]       way_we, way_inv, way_tag;
    logic [DATA_WIDTH-1:0] way_rdata [WAYS];

    logic                  hit_any;
    logic [DATA_WIDTH-1:0] hit_data;
    logic [WW-1:0]         vic;
    logic                  vic_ptr;

    logic                  stall_c, mem_read_c, mem_write_c;
    logic [ADDR_WIDTH-1:0] mem_addr_c;
    logic [DATA_WIDTH-1:0] mem_wdata_c;
    logic                  start_refill, refill_we, refill_last;
    logic                  store_we, flush_c;

    logic [IW-1:0]         wr_idx;
    logic [OW-1:0]         wr_off;
    logic [DATA_WIDTH-1:0] wr_data;

    assign req_off  = req_addr[OW-1:0];
    assign req_idx  = req_addr[OW +: IW];
    assign req_tag  = req_addr[ADDR_WIDTH-1 -: TW];
    assign line_idx = line_q[IW-1:0];
    assign line_tag = line_q[LW-1 -: TW];

    assign wr_idx  = refill_we ? line_idx  : req_idx;
    assign wr_off  = refill_we ? cnt_q     : req_off;
    assign wr_data = refill_we ? mem_rdata : req_wdata;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_way #(
            .DATA_WIDTH (DATA_WIDTH),
            .N_SETS     (NS),
            .IDX_W      (IW),
            .OFF_W      (OW),
            .TG_W       (TW)
        ) u_way (
            .clock     (clock),
            .reset     (reset),
            .flush_all (flush_c),
            .rd_index  (req_idx),
            .rd_offset (req_off),
            .rd_tag    (req_tag),
            .hit       (way_hit[w]),
            .valid     (way_valid[w]),
            .rdata     (way_rdata[w]),
            .wr_en     (way_we[w]),
            .wr_index  (wr_idx),
            .wr_offset (wr_off),
            .wr_data   (wr_data),
            .inv_en    (way_inv[w]),
            .tag_en    (way_tag[w]),
            .wr_tag    (line_tag)
        );
    end

    // Hit mux: at most one way hits, so OR-ing the qualified words is exact.
    always_comb begin
        hit_any  = |way_hit;
        hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) hit_data = hit_data | way_rdata[w];
        end
    end

    // Victim: lowest invalid way, else the set's round-robin pointer.
    always_comb begin
        vic     = ptr_q[req_idx];
        vic_ptr = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) begin
                vic     = WW'(w);
                vic_ptr = 1'b0;
            end
        end
    end

    // Per-way write strobes for refill words, store updates, invalidate and tag.
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            way_we[w]  = (refill_we && victim_q == WW'(w)) ||
                         (store_we && way_hit[w]);
            way_inv[w] = start_refill && (vic == WW'(w));
            way_tag[w] = refill_last && (victim_q == WW'(w));
        end
    end

    // Next state, stall and memory strobes.
    always_comb begin
        state_d      = state_q;
        stall_c      = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        mem_addr_c   = '0;
        mem_wdata_c  = '0;
        start_refill = 1'b0;
        refill_we    = 1'b0;
        refill_last  = 1'b0;
        store_we     = 1'b0;
        flush_c      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    stall_c = 1'b1;
                    flush_c = 1'b1;
                end else if (req_valid) begin
                    if (req_write) begin
                        stall_c = 1'b1;
                        state_d = ST_WRITE;
                    end else if (!hit_any) begin
                        stall_c      = 1'b1;
                        start_refill = 1'b1;
                        state_d      = ST_REFILL;
                    end
                end
            end
            ST_REFILL: begin
                stall_c    = 1'b1;
                mem_read_c = 1'b1;
                mem_addr_c = {line_q, cnt_q};
                if (mem_ready) begin
                    refill_we = 1'b1;
                    if (cnt_q == '1) begin
                        refill_last = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_WRITE: begin
                mem_write_c = 1'b1;
                mem_addr_c  = req_addr;
                mem_wdata_c = req_wdata;
                stall_c     = !mem_ready;
                if (mem_ready) begin
                    store_we = hit_any;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, refill bookkeeping and round-robin pointers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            line_q    <= '0;
            cnt_q     <= '0;
            victim_q  <= '0;
            use_ptr_q <= 1'b0;
            for (int s = 0; s < NS; s++) ptr_q[s] <= '0;
        end else begin
            state_q <= state_d;
            if (flush_c) begin
                for (int s = 0; s < NS; s++) ptr_q[s] <= '0;
            end
            if (start_refill) begin
                line_q    <= req_addr[ADDR_WIDTH-1:OW];
                cnt_q     <= '0;
                victim_q  <= vic;
                use_ptr_q <= vic_ptr;
            end
            if (refill_we) cnt_q <= cnt_q + 1'b1;
            if (refill_last && use_ptr_q) begin
                ptr_q[line_idx] <= (ptr_q[line_idx] == WW'(WAYS - 1)) ?
                                   '0 : ptr_q[line_idx] + 1'b1;
            end
        end
    end

    assign stall      = stall_c && reset;
    assign hit        = hit_any && req_valid && reset;
    assign mem_read   = mem_read_c && reset;
    assign mem_write  = mem_write_c && reset;
    assign mem_addr   = reset ? mem_addr_c  : '0;
    assign mem_wdata  = reset ? mem_wdata_c : '0;
    assign rdata_resp = (hit && !req_write && !stall_c) ? hit_data : '0;

`ifdef CACHE_STATS_EN
    logic hit_evt;

    assign hit_evt = (state_q == ST_IDLE) && !flush && req_valid &&
                     !req_write && hit_any;

    // Saturating event counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_evt && hit_count != '1)
                hit_count <= hit_count + 1'b1;
            if (start_refill && miss_count != '1)
                miss_count <= miss_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_assoc.sv
// Directed self-checking bench for cache_assoc with a transaction-level cache model.
// Memory word i initially holds 32'hC0DE0000 | i.
module tb_cache_assoc;

    localparam int WAYS = 2;
    localparam int WPL  = 4;
    localparam int SETS = 64 / WAYS;

    logic        clock, reset;
    logic        req_valid, req_write, flush;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall, hit, mem_read, mem_write, mem_ready;
    logic [31:0] rdata_resp, mem_wdata, mem_rdata;
    logic [15:0] mem_addr;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    cache_assoc dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .flush      (flush),
        .stall      (stall),
        .hit        (hit),
        .rdata_resp (rdata_resp),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
`ifdef CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] mem [0:65535];
    assign mem_rdata = mem[mem_addr];

    always @(posedge clock) begin
        if (mem_write && mem_ready) mem[mem_addr] <= mem_wdata;
    end

    int n_cmp = 0;
    int n_err = 0;
    int n_hit = 0;
    int n_miss = 0;

    bit mv   [SETS][WAYS];
    int mt   [SETS][WAYS];
    int mptr [SETS];

    function automatic int m_lookup(input logic [15:0] a);
        int s, t;
        s = (int'(a) / WPL) % SETS;
        t = int'(a) / (WPL * SETS);
        for (int w = 0; w < WAYS; w++)
            if (mv[s][w] && mt[s][w] == t) return w;
        return -1;
    endfunction

    function automatic void m_fill(input logic [15:0] a);
        int s, t, v;
        s = (int'(a) / WPL) % SETS;
        t = int'(a) / (WPL * SETS);
        v = -1;
        for (int w = 0; w < WAYS; w++)
            if (!mv[s][w] && v < 0) v = w;
        if (v < 0) begin
            v = mptr[s];
            mptr[s] = (mptr[s] + 1) % WAYS;
        end
        mv[s][v] = 1'b1;
        mt[s][v] = t;
    endfunction

    function automatic void m_clear();
        for (int s = 0; s < SETS; s++) begin
            mptr[s] = 0;
            for (int w = 0; w < WAYS; w++) mv[s][w] = 1'b0;
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    bit          exp_en = 1'b0;
    logic        e_stall, e_hit, e_rd, e_wr, e_rdchk;
    logic [15:0] e_addr;
    logic [31:0] e_wdata, e_rdata;

    task automatic set_exp(input logic s, input logic h, input logic r,
                           input logic w, input logic [15:0] a,
                           input logic [31:0] wd, input logic rc,
                           input logic [31:0] rdv);
        e_stall = s; e_hit = h; e_rd = r; e_wr = w;
        e_addr = a; e_wdata = wd; e_rdchk = rc; e_rdata = rdv;
        exp_en = 1'b1;
    endtask

    // Per-cycle comparison against the expectations published by the driver.
    always @(negedge clock) begin
        if (exp_en) begin
            chk("stall", stall, e_stall);
            chk("hit", hit, e_hit);
            chk("mem_read", mem_read, e_rd);
            chk("mem_write", mem_write, e_wr);
            if (e_rd || e_wr) chk("mem_addr", mem_addr, e_addr);
            if (e_wr) chk("mem_wdata", mem_wdata, e_wdata);
            if (e_rdchk) chk("rdata_resp", rdata_resp, e_rdata);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [15:0] a, input int lit_hit,
                           input int lit_stall, output logic [31:0] rd);
        int way, ns;
        logic fh;
        logic [15:0] base;
        ns = 0;
        rd = '0;
        req_valid = 1'b1; req_write = 1'b0;
        req_addr = a; req_wdata = '0; mem_ready = 1'b1;
        way = m_lookup(a);
        if (way >= 0) begin
            set_exp(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b1, mem[a]);
            #2; fh = hit; rd = rdata_resp; if (stall) ns++;
            step();
        end else begin
            set_exp(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
            #2; fh = hit; if (stall) ns++;
            step();
            base = a & 16'hFFFC;
            for (int k = 0; k < WPL; k++) begin
                set_exp(1'b1, 1'b0, 1'b1, 1'b0, base + 16'(k), '0, 1'b0, '0);
                #2; if (stall) ns++;
                step();
            end
            m_fill(a);
            n_miss++;
            set_exp(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b1, mem[a]);
            #2; rd = rdata_resp; if (stall) ns++;
            step();
        end
        n_hit++;
        exp_en = 1'b0;
        req_valid = 1'b0;
        if (lit_hit >= 0) chk("load_first_hit", {31'd0, fh}, lit_hit);
        if (lit_stall >= 0) chk("load_stall_cycles", ns, lit_stall);
    endtask

    task automatic do_store(input logic [15:0] a, input logic [31:0] d,
                            input int lit_hit);
        logic h, fh;
        int ns;
        ns = 0;
        h = (m_lookup(a) >= 0);
        req_valid = 1'b1; req_write = 1'b1;
        req_addr = a; req_wdata = d; mem_ready = 1'b1;
        set_exp(1'b1, h, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        #2; fh = hit; if (stall) ns++;
        step();
        set_exp(1'b0, h, 1'b0, 1'b1, a, d, 1'b0, '0);
        #2; if (stall) ns++;
        step();
        exp_en = 1'b0;
        req_valid = 1'b0; req_write = 1'b0;
        chk("store_hit", {31'd0, fh}, lit_hit);
        chk("store_stall_cycles", ns, 1);
    endtask

    task automatic do_flush();
        int ns;
        ns = 0;
        req_valid = 1'b0;
        flush = 1'b1;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        #2; if (stall) ns++;
        step();
        flush = 1'b0;
        m_clear();
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        #2; if (stall) ns++;
        step();
        exp_en = 1'b0;
        chk("flush_stall_cycles", ns, 1);
    endtask

    logic [31:0] rd;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'hC0DE0000 | i;
        m_clear();
        reset = 1'b0; flush = 1'b0; mem_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b0;
        req_addr = 16'h0040; req_wdata = '0;
        #3;
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_hit", {31'd0, hit}, 0);
        chk("rst_mem_read", {31'd0, mem_read}, 0);
        chk("rst_mem_write", {31'd0, mem_write}, 0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 0);
        chk("rst_rdata", rdata_resp, 0);
        req_valid = 1'b0;
        step(); step();
        reset = 1'b1;
        step();

        do_load(16'h0040, 0, 5, rd);
        chk("fill_0040_data", rd, 32'hC0DE0040);
        do_load(16'h0042, 1, 0, rd);
        chk("hit_0042_data", rd, 32'hC0DE0042);

        do_load(16'h0000, 0, 5, rd);
        do_load(16'h0080, 0, 5, rd);
        do_load(16'h0100, 0, 5, rd);
        do_load(16'h0080, 1, 0, rd);
        do_load(16'h0000, 0, 5, rd);
        chk("reload_0000_data", rd, 32'hC0DE0000);

        do_store(16'h0041, 32'hDEADBEEF, 1);
        do_load(16'h0041, 1, 0, rd);
        chk("load_after_store", rd, 32'hDEADBEEF);
        do_store(16'h2000, 32'h12345678, 0);
        do_load(16'h2000, 0, 5, rd);
        chk("no_allocate_data", rd, 32'h12345678);

        do_flush();
        do_load(16'h0040, 0, 5, rd);

        do_flush();
        req_valid = 1'b1; req_write = 1'b0;
        req_addr = 16'h0040; mem_ready = 1'b0;
        step();
        mem_ready = 1'b1;
        step(); step();
        mem_ready = 1'b0;
        #2;
        chk("mid_refill_read", {31'd0, mem_read}, 1);
        chk("mid_refill_addr", {16'd0, mem_addr}, 32'h0042);
        reset = 1'b0;
        #1;
        chk("rst_read_drop", {31'd0, mem_read}, 0);
        chk("rst_stall_drop", {31'd0, stall}, 0);
        step();
        reset = 1'b1; req_valid = 1'b0; mem_ready = 1'b1;
        m_clear();
        n_hit = 0; n_miss = 0;
        step();
        do_load(16'h0040, 0, 5, rd);
        do_load(16'h0043, 1, 0, rd);
        chk("after_reset_data", rd, 32'hC0DE0043);

`ifdef CACHE_STATS_EN
        chk("hit_count", hit_count, n_hit);
        chk("miss_count", miss_count, n_miss);
        chk("hit_count_lit", hit_count, 2);
        chk("miss_count_lit", miss_count, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_assoc.md
# cache_assoc

Parametrised set-associative data cache between the RISC-V pipeline's MEM stage and main memory, the successor of the single-way cache. Generalises associativity (WAYS) and line size (WORDS_PER_LINE), adds a multi-word refill state machine with a memory handshake, write-through stores with no-write-allocate, per-set round-robin replacement and a one-cycle flush. Read hits return data combinationally in the request cycle. Misses and stores stall the pipeline until memory completes.

## Interface
- ADDR_WIDTH, 16: width of the word address.
- DATA_WIDTH, 32: width of a data word.
- NUM_LINES, 64: total lines across all ways; power of 2.
- WAYS, 2: associativity; 1, 2 or 4.
- WORDS_PER_LINE, 4: words per line; power of 2, at least 2.
- clock  in  1  single clock domain; rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  processor access request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  store data.
- flush  in  1  invalidate all lines.
- stall  out  1  processor must hold its request and its pipeline.
- hit  out  1  lookup hit (valid only when req_valid).
- rdata_resp  out  DATA_WIDTH  load data; valid when hit && !req_write && !stall.
- mem_read, mem_write  out  1  memory read and write requests.
- mem_addr  out  ADDR_WIDTH  memory word address.
- mem_wdata  out  DATA_WIDTH  memory store data.
- mem_rdata  in  DATA_WIDTH  memory read data; valid with mem_ready.
- mem_ready  in  1  memory completes the current word this cycle.

## Operation
- Address split: offset = low log2(WORDS_PER_LINE) bits. Index = next log2(NUM_LINES/WAYS) bits. Tag = remaining bits.
- Hit: any way in the indexed set has valid set and a tag equal to the request tag. At most one way hits.
- FSM states: IDLE, REFILL, WRITE.
- IDLE, load hit: rdata_resp = the hit word; stall = 0; no memory access.
- IDLE, load miss: stall = 1. Latch the line base address and pick the victim way. Go to REFILL.
- Victim selection: the lowest-index invalid way; if no way is invalid, the way given by the set's round-robin pointer. After a refill that used the pointer, the pointer increments mod WAYS.
- REFILL: mem_read = 1 and mem_addr = line base + word counter. On each mem_ready, write mem_rdata into the victim way and increment the counter. On the last word, write the tag, set valid and return to IDLE. The request is then looked up again and hits.
- IDLE, store: stall = 1; go to WRITE.
- WRITE: mem_write = 1, mem_addr = req_addr, mem_wdata = req_wdata. On mem_ready, update the cached word if the store hits (no allocate on a miss), set stall = 0 and return to IDLE.
- Flush in IDLE: at the next edge, clear all valid bits and all round-robin pointers. stall = 1 during the flush cycle. If req_valid is also high, the request is handled the cycle after the flush and therefore misses.
- Flush outside IDLE: held off. The requester keeps flush asserted until stall = 0.
- The processor holds req_* stable while stall = 1.

## Timing
- Reset (asynchronous, active low): state = IDLE; all valid bits, pointers and counters = 0; stall, hit, mem_read, mem_write = 0; mem_addr, mem_wdata, rdata_resp = 0.
- Reset mid-refill or mid-write: memory strobes drop immediately and the partial line is never validated.
- Load hit latency: 0 cycles.
- Load miss latency: WORDS_PER_LINE memory handshakes plus 1 lookup cycle. With mem_ready tied high, stall lasts WORDS_PER_LINE+1 cycles.
- Store latency: 1 cycle plus the memory wait. With mem_ready tied high, stall is high for exactly 1 cycle.
- mem_addr and mem_wdata are stable while mem_read or mem_write is high. mem_read and mem_write are never high together.

## Configuration
- CACHE_STATS_EN defined: adds outputs hit_count and miss_count, each 32 bits.
  - hit_count increments once per completed load hit; miss_count increments once per refill started.
  - Both counters saturate at all-ones and are cleared by reset.
- CACHE_STATS_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package cache_pkg: FSM state enum; localparams OFFSET_W, INDEX_W, TAG_W and SETS derived with $clog2.
- Sub-module cache_way: holds one way's valid, tag and data arrays, does its own tag compare and exposes hit, rdata and a write port. Instantiated WAYS times.
- Top level: FSM, victim selection and pointers, hit mux, memory interface.

## Test plan
- Defaults, mem_ready tied high: after reset, load 0x0040.
  - Miss: mem_read with mem_addr 0x0040, 0x0041, 0x0042, 0x0043.
  - stall high for 5 cycles, then hit with rdata_resp equal to memory word 0x0040.
- Load 0x0042 after that fill -> hit in the request cycle, stall = 0, mem_read never asserted.
- Loads to 0x0000, 0x0080 and 0x0100 (same set, index 0):
  - The third load evicts way 0.
  - A following load of 0x0000 misses; a following load of 0x0080 hits.
- Store 0xDEADBEEF to cached address 0x0041:
  - mem_write with mem_addr 0x0041; a following load returns 0xDEADBEEF without a refill.
  - A store to uncached 0x2000 followed by a load of 0x2000 misses (no allocate).
- Reset low after 2 refill words of 0x0040 (mem_ready throttled):
  - mem_read drops immediately.
  - After release, a load of 0x0040 misses again.
- Flush after filling 0x0040: stall high for 1 cycle, then a load of 0x0040 misses. With CACHE_STATS_EN defined, hit_count and miss_count match the scenario totals.
